// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter built from toggle bit cells, with load, wrap/saturate/one-shot modes.
// Latency: q, wrap_pulse and busy update one cycle after the sampling edge; tc is combinational from q and up.
// No backpressure: en is a per-cycle advance request; priority is rst > load > count.
module tff_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             busy
);

  // MODULUS may equal 2**WIDTH, so range compares are done one bit wider.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);

  localparam logic [1:0] MODE_WRAP  = 2'b00;
  localparam logic [1:0] MODE_SAT   = 2'b01;
  localparam logic [1:0] MODE_SHOT  = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_nxt;
  logic             carry;
  logic             oor;
  logic             at_term;
  logic             pulse_nxt;

  // Terminal value depends on direction; out-of-range q is treated as terminal for stepping only.
  assign term    = up ? LAST : '0;
  assign tc      = (q == term);
  assign oor     = ({1'b0, q} >= MOD_EXT);
  assign at_term = tc | oor;

  // Toggle enables: a bit flips when en is high and every lower bit is 1 (up) or 0 (down).
  always_comb begin
    t     = '0;
    carry = en;
    for (int i = 0; i < WIDTH; i++) begin
      t[i]  = carry;
      carry = carry & (up ? q[i] : ~q[i]);
    end
  end

  assign q_step = q ^ t;

  // Next count, one-shot state and pulse request for this edge.
  always_comb begin
    q_nxt     = q;
    state_nxt = state;
    pulse_nxt = 1'b0;
    if (load) begin
      q_nxt     = ({1'b0, load_val} < MOD_EXT) ? load_val : LAST;
      state_nxt = S_IDLE;
    end else if (mode == MODE_SHOT) begin
      case (state)
        S_IDLE: begin
          if (start) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (en) begin
            if (at_term) begin
              // Armed while already at terminal: finish without moving.
              state_nxt = S_DONE;
              pulse_nxt = 1'b1;
            end else begin
              q_nxt = q_step;
              if (q_step == term) begin
                state_nxt = S_DONE;
                pulse_nxt = 1'b1;
              end
            end
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end else begin
      // Wrap (00/11) and saturate (01); leaving one-shot always drops the FSM to idle.
      state_nxt = S_IDLE;
      if (en) begin
        if (at_term) begin
          if (mode != MODE_SAT) begin
            q_nxt     = up ? '0 : LAST;
            pulse_nxt = 1'b1;
          end
        end else begin
          q_nxt = q_step;
        end
      end
    end
  end

  // Register count, FSM state and the registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= '0;
      state      <= S_IDLE;
      wrap_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      q          <= q_nxt;
      state      <= state_nxt;
      wrap_pulse <= pulse_nxt;
      busy       <= (state_nxt == S_RUN);
    end
  end

  // MODE_WRAP documents the default branch encoding; reference it so it is not flagged unused.
  logic unused_mode_wrap;
  assign unused_mode_wrap = ^MODE_WRAP;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Self-checking bench for tff_mod_counter (WIDTH=4, MODULUS=10).
// Directed scenarios followed by randomized traffic, all checked against an integer reference model.
// Inputs change 1 ns after each rising edge; outputs are compared at that same point.
module tb_tff_mod_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic             clk;
  logic             rst;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [1:0]       mode;
  logic             start;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap_pulse;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: count as a plain integer, one-shot phase as a name-like code.
  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;
  int m_q     = 0;
  int m_phase = PH_IDLE;
  int m_pulse = 0;
  int m_busy  = 0;

  tff_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_val   (load_val),
    .mode       (mode),
    .start      (start),
    .q          (q),
    .tc         (tc),
    .wrap_pulse (wrap_pulse),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge from the current input values.
  task automatic model_edge();
    int term;
    bit at_end;
    term   = up ? MODULUS - 1 : 0;
    at_end = (m_q == term) || (m_q >= MODULUS);
    m_pulse = 0;
    if (rst) begin
      m_q     = 0;
      m_phase = PH_IDLE;
    end else if (load) begin
      m_q     = (int'(load_val) < MODULUS) ? int'(load_val) : MODULUS - 1;
      m_phase = PH_IDLE;
    end else if (mode == 2'b10) begin
      if (m_phase == PH_IDLE) begin
        if (start) m_phase = PH_RUN;
      end else if (m_phase == PH_RUN) begin
        if (en) begin
          if (!at_end) m_q = up ? m_q + 1 : m_q - 1;
          if (at_end || m_q == term) begin
            m_phase = PH_DONE;
            m_pulse = 1;
          end
        end
      end else begin
        m_phase = PH_IDLE;
      end
    end else begin
      m_phase = PH_IDLE;
      if (en) begin
        if (!at_end) begin
          m_q = up ? m_q + 1 : m_q - 1;
        end else if (mode != 2'b01) begin
          m_q     = up ? 0 : MODULUS - 1;
          m_pulse = 1;
        end
      end
    end
    m_busy = (m_phase == PH_RUN) ? 1 : 0;
  endtask

  task automatic check_outputs();
    int term;
    term = up ? MODULUS - 1 : 0;
    chk("q", int'(q), m_q);
    chk("tc", int'(tc), (m_q == term) ? 1 : 0);
    chk("wrap_pulse", int'(wrap_pulse), m_pulse);
    chk("busy", int'(busy), m_busy);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_load(input int v);
    load     = 1'b1;
    load_val = WIDTH'(v);
    tick();
    load     = 1'b0;
  endtask

  int seen_pulse;

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; mode = 2'b00; start = 1'b0;
    tick();
    chk("reset_q", int'(q), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulse", int'(wrap_pulse), 0);
    rst = 1'b0;

    // Wrap counting up through the terminal.
    en = 1'b1; up = 1'b1; mode = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("t1_seq", int'(q), i % MODULUS);
      chk("t1_pulse", int'(wrap_pulse), (i == MODULUS) ? 1 : 0);
    end

    // Wrap counting down from zero.
    en = 1'b0;
    do_load(0);
    up = 1'b0; en = 1'b1;
    tick(); chk("t2_q9", int'(q), 9); chk("t2_pulse", int'(wrap_pulse), 1);
    tick(); chk("t2_q8", int'(q), 8); chk("t2_nopulse", int'(wrap_pulse), 0);
    tick(); chk("t2_q7", int'(q), 7);

    // Saturate at the top.
    en = 1'b0; up = 1'b1; mode = 2'b01;
    do_load(7);
    en = 1'b1;
    seen_pulse = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen_pulse |= int'(wrap_pulse);
    end
    chk("t3_sat_q", int'(q), 9);
    chk("t3_sat_tc", int'(tc), 1);
    chk("t3_no_pulse", seen_pulse, 0);

    // Out-of-range load clamps; load beats a simultaneous enable.
    en = 1'b0;
    do_load(13);
    chk("t4_clamp", int'(q), 9);
    en = 1'b1;
    do_load(2);
    chk("t4_load_wins", int'(q), 2);

    // One-shot run from 0 with a retrigger attempt mid-run.
    en = 1'b0; mode = 2'b10; up = 1'b1;
    do_load(0);
    en = 1'b1; start = 1'b1;
    tick();
    chk("t5_armed_q", int'(q), 0);
    chk("t5_busy", int'(busy), 1);
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t5_hold_q", int'(q), 9);
    chk("t5_idle", int'(busy), 0);
    repeat (3) tick();
    chk("t5_frozen", int'(q), 9);

    // Reset mid run, then leave one-shot mode mid run.
    do_load(0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    chk("t6_mid", int'(q), 5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_q", int'(q), 0);
    chk("t6_rst_busy", int'(busy), 0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    mode = 2'b00; tick();
    chk("t6_leave_busy", int'(busy), 0);
    repeat (10) tick();

    // Randomized traffic, including the 11 mode encoding and direction flips.
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 60) == 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = WIDTH'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) up = ~up;
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
